// File: rtl/mcu_pkg.sv
// Shared MCU definitions: fetch state encoding and default fetch widths.
package mcu_pkg;

  localparam int unsigned ADDR_W_DEFAULT      = 8;
  localparam int unsigned DATA_W_DEFAULT      = 8;
  localparam int unsigned OPERAND_BIT_DEFAULT = 7;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2,
    HALTED    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: steps the PC, reads opcode/operand bytes into the IR and
// issues them to execute over valid/ready, with branch redirect and halt.
module instruction_fetch_unit
  import mcu_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned OPERAND_BIT = OPERAND_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              load_pc,
  output logic              inc_pc,
  output logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              halted
);

  fetch_state_e state, next_state;
  logic         latch_op;
  logic         latch_arg;
  logic         clear_arg;

  assign mem_addr = pc_value;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH_OP;
    else       state <= next_state;
  end

  // Next state and PC strobes; the PC clears on a strobe-free cycle, so the
  // default is an explicit hold via load_pc with the current value.
  always_comb begin
    next_state = state;
    load_pc    = 1'b1;
    inc_pc     = 1'b0;
    pc_in      = pc_value;
    mem_rd     = (state == FETCH_OP) || (state == FETCH_ARG);
    halted     = (state == HALTED);
    latch_op   = 1'b0;
    latch_arg  = 1'b0;
    clear_arg  = 1'b0;

    if (branch_taken) begin
      pc_in      = branch_target;
      next_state = FETCH_OP;
    end else begin
      case (state)
        FETCH_OP: begin
          if (mem_ready) begin
            latch_op = 1'b1;
            load_pc  = 1'b0;
            inc_pc   = 1'b1;
            if (mem_rdata[OPERAND_BIT]) begin
              next_state = FETCH_ARG;
            end else begin
              clear_arg  = 1'b1;
              next_state = ISSUE;
            end
          end else if (halt) begin
            next_state = HALTED;
          end
        end
        FETCH_ARG: begin
          if (mem_ready) begin
            latch_arg  = 1'b1;
            load_pc    = 1'b0;
            inc_pc     = 1'b1;
            next_state = ISSUE;
          end
        end
        ISSUE: begin
          if (instr_valid && instr_ready) next_state = halt ? HALTED : FETCH_OP;
        end
        HALTED: begin
          if (!halt) next_state = FETCH_OP;
        end
        default: next_state = FETCH_OP;
      endcase
    end

    if (reset) begin
      load_pc = 1'b0;
      inc_pc  = 1'b0;
      mem_rd  = 1'b0;
      halted  = 1'b0;
      pc_in   = '0;
    end
  end

  // Instruction register and valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_opcode   <= '0;
      ir_operand  <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (latch_op) ir_opcode <= mem_rdata;
      if (latch_arg)      ir_operand <= mem_rdata;
      else if (clear_arg) ir_operand <= '0;
      instr_valid <= (next_state == ISSUE);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a behavioural PC stage,
// a byte-wide program memory and an expected-instruction scoreboard.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc_value;
  logic       load_pc, inc_pc;
  logic [7:0] pc_in, mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_ready = 1'b0;
  logic [7:0] ir_opcode, ir_operand;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       halt = 1'b0;
  logic       halted;

  logic [7:0]  mem [0:255];
  logic [7:0]  pc;
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // program_counter model: load, increment, otherwise clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pc <= 8'h00;
    else if (load_pc) pc <= pc_in;
    else if (inc_pc)  pc <= pc + 8'h01;
    else              pc <= 8'h00;
  end
  assign pc_value  = pc;
  assign mem_rdata = mem[mem_addr];

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_value(pc_value), .load_pc(load_pc),
    .inc_pc(inc_pc), .pc_in(pc_in), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .halted(halted)
  );

  task automatic wait_valid(input int max_cycles, output int cycles, output int incs,
                            output bit timed_out);
    cycles = 0; incs = 0; timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (instr_valid) begin timed_out = 1'b0; break; end
      cycles++;
      incs += int'(inc_pc);
    end
  endtask

  task automatic do_branch(input logic [7:0] tgt);
    @(negedge clk);
    branch_taken = 1'b1; branch_target = tgt;
    @(posedge clk); #1;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests_run++;
    if ({mem_rd, inc_pc, load_pc, halted, instr_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 00000", {mem_rd, inc_pc, load_pc, halted, instr_valid});
    end
    tests_run++;
    if ({pc_in, ir_opcode, ir_operand} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 000000", {pc_in, ir_opcode, ir_operand});
    end
  endtask

  task automatic test_one_byte;
    mem[0] = 8'h12;
    exp_q.push_back(16'h1200);
    @(negedge clk);
    mem_ready = 1'b1; reset = 1'b0;
    #1;
    tests_run++;
    if ({inc_pc, load_pc, mem_rd, mem_addr} !== {3'b101, 8'h00}) begin
      tests_failed++;
      $display("FAIL first_fetch: got inc/load/rd/addr %b%b%b %h want 101 00", inc_pc, load_pc, mem_rd, mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (instr_valid !== 1'b1 || pc !== 8'h01) begin
      tests_failed++;
      $display("FAIL one_byte_latency: got valid=%b pc=%h want 1 01", instr_valid, pc);
    end
    instr_ready = 1'b1;
    tests_run++;
    exp_v = exp_q.pop_front();
    if ({ir_opcode, ir_operand} !== exp_v) begin
      tests_failed++;
      $display("FAIL one_byte_ir: got %h want %h", {ir_opcode, ir_operand}, exp_v);
    end
    @(posedge clk); #1;
    instr_ready = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pc !== 8'h01 || mem_addr !== 8'h01 || mem_rd !== 1'b1 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL next_fetch: got pc=%h addr=%h rd=%b valid=%b want 01 01 1 0", pc, mem_addr, mem_rd, instr_valid);
    end
  endtask

  task automatic test_two_byte;
    int cyc, incs; bit to;
    mem[8'h05] = 8'h83; mem[8'h06] = 8'h44;
    mem_ready = 1'b1;
    do_branch(8'h05);
    exp_q.push_back(16'h8344);
    wait_valid(20, cyc, incs, to);
    tests_run++;
    if (to || cyc != 2 || incs != 2 || pc !== 8'h07) begin
      tests_failed++;
      $display("FAIL two_byte_timing: got timeout=%0b cycles=%0d incs=%0d pc=%h want 0 2 2 07", to, cyc, incs, pc);
    end
    instr_ready = 1'b1;
    tests_run++;
    exp_v = exp_q.pop_front();
    if ({ir_opcode, ir_operand} !== exp_v) begin
      tests_failed++;
      $display("FAIL two_byte_ir: got %h want %h", {ir_opcode, ir_operand}, exp_v);
    end
    @(posedge clk); #1;
    instr_ready = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_wait_states;
    int cyc, incs; bit to;
    mem[8'h10] = 8'h21;
    do_branch(8'h10);
    exp_q.push_back(16'h2100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({load_pc, inc_pc} !== 2'b10 || pc_in !== 8'h10 || pc !== 8'h10 || mem_addr !== 8'h10) begin
        tests_failed++;
        $display("FAIL wait_hold[%0d]: got load/inc=%b%b pc_in=%h pc=%h addr=%h want 10 10 10 10",
                 i, load_pc, inc_pc, pc_in, pc, mem_addr);
      end
    end
    mem_ready = 1'b1;
    wait_valid(20, cyc, incs, to);
    instr_ready = 1'b1;
    tests_run++;
    exp_v = exp_q.pop_front();
    if (to || {ir_opcode, ir_operand} !== exp_v || pc !== 8'h11) begin
      tests_failed++;
      $display("FAIL wait_ir: got to=%0b ir=%h pc=%h want 0 %h 11", to, {ir_opcode, ir_operand}, pc, exp_v);
    end
    @(posedge clk); #1;
    instr_ready = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_stall_then_branch;
    int cyc, incs; bit to;
    mem[8'h20] = 8'h05;
    mem_ready = 1'b1;
    do_branch(8'h20);
    exp_q.push_back(16'h0500);
    wait_valid(20, cyc, incs, to);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (to || instr_valid !== 1'b1 || ir_opcode !== 8'h05 || load_pc !== 1'b1 || pc_in !== 8'h21) begin
        tests_failed++;
        $display("FAIL stall_stable[%0d]: got valid=%b op=%h load=%b pc_in=%h want 1 05 1 21",
                 i, instr_valid, ir_opcode, load_pc, pc_in);
      end
    end
    branch_taken = 1'b1; branch_target = 8'h40; instr_ready = 1'b1;
    #1;
    tests_run++;
    if ({load_pc, inc_pc} !== 2'b10 || pc_in !== 8'h40) begin
      tests_failed++;
      $display("FAIL branch_strobe: got load/inc=%b%b pc_in=%h want 10 40", load_pc, inc_pc, pc_in);
    end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    branch_taken = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (instr_valid !== 1'b0 || pc !== 8'h40 || mem_addr !== 8'h40 || mem_rd !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_flush: got valid=%b pc=%h addr=%h rd=%b want 0 40 40 1", instr_valid, pc, mem_addr, mem_rd);
    end
  endtask

  task automatic test_wrap;
    int cyc, incs; bit to;
    mem[8'hFF] = 8'h90; mem[8'h00] = 8'h11;
    mem_ready = 1'b1;
    do_branch(8'hFF);
    exp_q.push_back(16'h9011);
    wait_valid(20, cyc, incs, to);
    instr_ready = 1'b1;
    tests_run++;
    exp_v = exp_q.pop_front();
    if (to || {ir_opcode, ir_operand} !== exp_v || pc !== 8'h01) begin
      tests_failed++;
      $display("FAIL wrap: got to=%0b ir=%h pc=%h want 0 %h 01", to, {ir_opcode, ir_operand}, pc, exp_v);
    end
    @(posedge clk); #1;
    instr_ready = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_halt;
    int cyc, incs; bit to;
    mem[8'h30] = 8'h07;
    halt = 1'b1;
    do_branch(8'h30);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({halted, mem_rd, load_pc, inc_pc} !== 4'b1010 || pc_in !== 8'h30) begin
      tests_failed++;
      $display("FAIL halt_enter: got halted/rd/load/inc=%b pc_in=%h want 1010 30", {halted, mem_rd, load_pc, inc_pc}, pc_in);
    end
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (halted !== 1'b1 || mem_rd !== 1'b0 || pc !== 8'h30) begin
      tests_failed++;
      $display("FAIL halt_hold: got halted=%b rd=%b pc=%h want 1 0 30", halted, mem_rd, pc);
    end
    halt = 1'b0;
    exp_q.push_back(16'h0700);
    wait_valid(20, cyc, incs, to);
    instr_ready = 1'b1;
    tests_run++;
    exp_v = exp_q.pop_front();
    if (to || {ir_opcode, ir_operand} !== exp_v || pc !== 8'h31 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_resume: got to=%0b ir=%h pc=%h halted=%b want 0 %h 31 0", to, {ir_opcode, ir_operand}, pc, halted, exp_v);
    end
    @(posedge clk); #1;
    instr_ready = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    mem[8'h50] = 8'h81;
    mem_ready = 1'b1;
    do_branch(8'h50);
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if (ir_opcode !== 8'h81 || mem_rd !== 1'b1 || pc !== 8'h51) begin
      tests_failed++;
      $display("FAIL arg_state: got op=%h rd=%b pc=%h want 81 1 51", ir_opcode, mem_rd, pc);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({mem_rd, inc_pc, load_pc, halted, instr_valid} !== 5'b0 ||
        {pc_in, ir_opcode, ir_operand} !== 24'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got ctrl=%b data=%h want 00000 000000",
               {mem_rd, inc_pc, load_pc, halted, instr_valid}, {pc_in, ir_opcode, ir_operand});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset;
    test_one_byte;
    test_two_byte;
    test_wait_states;
    test_stall_then_branch;
    test_wrap;
    test_halt;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch sequencer sitting directly downstream of program_counter and feeding the execute stage. It drives the PC strobes, reads opcode and optional operand bytes from program memory at the current PC, and latches them into an instruction register. It presents the instruction to execute over a valid/ready handshake and redirects the PC on taken branches.

Parameters:
ADDR_W, 8, program address width (equals PC width)
DATA_W, 8, instruction byte width
OPERAND_BIT, 7, opcode bit that, when 1, marks a two-byte instruction (operand follows)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pc_value  in  ADDR_W  current PC from program_counter
load_pc  out  1  PC load strobe
inc_pc  out  1  PC increment strobe
pc_in  out  ADDR_W  PC load value
mem_addr  out  ADDR_W  program memory read address
mem_rd  out  1  read request
mem_rdata  in  DATA_W  read data, valid when mem_ready=1
mem_ready  in  1  read completes this cycle
ir_opcode  out  DATA_W  latched opcode
ir_operand  out  DATA_W  latched operand (0 for one-byte instructions)
instr_valid  out  1  instruction available to execute
instr_ready  in  1  execute accepts instruction
branch_taken  in  1  single-cycle redirect request from execute
branch_target  in  ADDR_W  redirect address
halt  in  1  level; stop fetching
halted  out  1  fetch unit is in HALTED

Behaviour:
- Reset is asynchronous and active-high on clock clk. Reset sends the state to FETCH_OP and clears ir_opcode, ir_operand and instr_valid to 0. While reset=1, mem_rd, inc_pc, load_pc and halted are forced to 0 and pc_in is 0.
- The PC stage clears to 0 on any cycle with neither strobe asserted. This block therefore drives a strobe every cycle: either inc_pc, or load_pc with pc_in=pc_value (hold), or load_pc with pc_in=branch_target. inc_pc and load_pc are never both 1.
- mem_addr=pc_value at all times. Strobes and mem_rd are combinational from state and inputs. IR fields and instr_valid are registered.
- States:
  - FETCH_OP: mem_rd=1. If mem_ready=1, latch ir_opcode=mem_rdata and assert inc_pc. Go to FETCH_ARG if mem_rdata[OPERAND_BIT]=1; otherwise set ir_operand=0 and go to ISSUE. If mem_ready=0, hold the PC and stay.
  - FETCH_ARG: mem_rd=1. If mem_ready=1, latch ir_operand, assert inc_pc and go to ISSUE. Otherwise hold.
  - ISSUE: instr_valid=1 and PC held. On instr_valid&&instr_ready, clear instr_valid and go to FETCH_OP, or to HALTED if halt=1.
  - HALTED: mem_rd=0, halted=1, PC held. When halt=0, return to FETCH_OP.
- Halt is sampled in FETCH_OP only before a read completes. halt=1 with mem_ready=0 enters HALTED. A read accepted in the same cycle as halt completes first.
- branch_taken has the highest priority, in any state including HALTED. That cycle: load_pc=1, pc_in=branch_target, inc_pc=0, the in-flight read is abandoned (mem_ready ignored), instr_valid clears next cycle, and the next state is FETCH_OP. An instruction in ISSUE is flushed without a handshake. A branch coinciding with instr_ready also wins, and the instruction is treated as flushed.
- Latency, zero-wait memory: one-byte instruction valid 1 cycle after entering FETCH_OP; two-byte instruction after 2 cycles. Throughput is one byte per cycle plus one ISSUE cycle minimum per instruction.
- Wrap-around: an opcode at 0xFF increments the PC to 0x00, and any operand is fetched from 0x00. No special casing.
- instr_valid, ir_opcode and ir_operand stay stable while instr_valid=1 and instr_ready=0. The only exceptions are branch and reset.

Decomposition:
- Shared package mcu_pkg holds:
  - the fetch state encoding FETCH_OP, FETCH_ARG, ISSUE, HALTED (2-bit)
  - the OPERAND_BIT constant
  - the ADDR_W and DATA_W defaults
- No sub-module is needed. The FSM and IR latches are a single module of about 150 lines.

Test Plan:
- Reset, then memory 0x00=0x12 with zero-wait -> inc_pc in cycle 1, ir_opcode=0x12, ir_operand=0x00, instr_valid in cycle 2. With instr_ready=1, PC=0x01 and the next fetch starts.
- Memory 0x05=0x83, 0x06=0x44, PC=0x05 -> two inc_pc pulses, ir_opcode=0x83, ir_operand=0x44, PC=0x07.
- mem_ready low for 3 cycles during FETCH_OP -> load_pc=1 with pc_in=pc_value each wait cycle, PC is never 0, mem_addr is stable.
- ISSUE with instr_ready=0 for 4 cycles, then branch_taken with target 0x40 -> instr_valid drops, PC=0x40, next mem_addr=0x40.
- PC=0xFF, opcode 0x90, operand at 0x00=0x11 -> ir_operand=0x11, PC=0x01.
- halt=1 in FETCH_OP with mem_ready=0 -> halted=1, mem_rd=0, PC held. Then halt=0 -> fetch resumes at the same PC. Async reset mid-FETCH_ARG -> all outputs 0 immediately.
